// File: rtl/dac_segment_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dac_segment_ctrl_pkg
// Description : Shared types and constants for the segmented DAC controller:
//               power FSM states, unit counts and the full-scale code.
// Revision    : 1.0 - initial release
// ============================================================================
package dac_segment_ctrl_pkg;

    // Array geometry: 17 thermometer units of 64 LSB plus a 6-bit binary part
    localparam int NUM_THERM = 17;
    localparam int NUM_BIN   = 6;

    // Largest representable code: 17 * 64 + 63
    localparam int CODE_MAX  = 1151;

    // Width of a thermometer unit count (0..17) and of the DWA pointer (0..16)
    localparam int SEL_W     = 5;

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_SETTLE = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/dwa_rotator.sv
`default_nettype none
// ============================================================================
// Module      : dwa_rotator
// Description : Builds the thermometer enable mask of n consecutive units
//               starting at ptr (wrapping modulo NUM_THERM), and the pointer
//               value that follows this selection.
// Revision    : 1.0 - initial release
// ============================================================================
module dwa_rotator
    import dac_segment_ctrl_pkg::*;
(
    input  logic [SEL_W-1:0]     n,
    input  logic [SEL_W-1:0]     ptr,
    output logic [NUM_THERM-1:0] mask,
    output logic [SEL_W-1:0]     ptr_next
);

    localparam logic [SEL_W:0] NT = (SEL_W+1)'(NUM_THERM);

    logic [SEL_W:0] ptr_x;
    logic [SEL_W:0] n_x;
    logic [SEL_W:0] sum;

    assign ptr_x = {1'b0, ptr};
    assign n_x   = {1'b0, n};
    assign sum   = ptr_x + n_x;

    // n = 0 and n = NUM_THERM both leave the pointer where it was
    assign ptr_next = (sum >= NT) ? SEL_W'(sum - NT) : sum[SEL_W-1:0];

    // Each unit is on when its distance ahead of the pointer is below n
    generate
        for (genvar i = 0; i < NUM_THERM; i++) begin : g_unit
            localparam logic [SEL_W:0] IDX = (SEL_W+1)'(i);
            logic [SEL_W:0] offset;
            assign offset  = (IDX >= ptr_x) ? (IDX - ptr_x) : (IDX + NT - ptr_x);
            assign mask[i] = (offset < n_x);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/dac_segment_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dac_segment_ctrl
// Description : Power sequencing and segment decoding for a segmented current
//               steering DAC: OFF/SETTLE/ACTIVE power FSM, code saturation,
//               thermometer decoding with optional DWA rotation, binary and
//               redundant-LSB switch steering, analog testbus select.
// Revision    : 1.0 - initial release
// ============================================================================
module dac_segment_ctrl
    import dac_segment_ctrl_pkg::*;
#(
    parameter int SETTLE_CYC = 16,
    parameter int CODE_W     = 11
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 dem_en,
    input  logic                 red_sel,
    input  logic [1:0]           atb_sel,
    input  logic                 code_valid,
    input  logic [CODE_W-1:0]    code,
    output logic                 code_ready,
    output logic                 pdb,
    output logic [1:0]           atb_ena,
    output logic [NUM_THERM-1:0] therm_sw,
    output logic [NUM_BIN-1:0]   bin_sw,
    output logic                 bin0_red_sw,
    output logic                 sat,
    output logic                 active
);

    localparam int CNT_W = ($clog2(SETTLE_CYC) < 1) ? 1 : $clog2(SETTLE_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYC - 1);

    state_t                 state;
    state_t                 state_next;
    logic [CNT_W-1:0]       settle_cnt;
    logic [SEL_W-1:0]       ptr;
    logic [SEL_W-1:0]       ptr_use;
    logic [SEL_W-1:0]       ptr_next;
    logic [NUM_THERM-1:0]   mask;
    logic                   accept;
    logic                   code_over;
    logic [CODE_W-1:0]      code_clip;
    logic [SEL_W-1:0]       n_units;
    logic [NUM_BIN-1:0]     b_bits;

    // Saturate the code and split it into thermometer count and binary part
    assign code_over = (code > CODE_W'(CODE_MAX));
    assign code_clip = code_over ? CODE_W'(CODE_MAX) : code;
    assign n_units   = code_clip[10:6];
    assign b_bits    = code_clip[5:0];

    // A falling en in the same cycle discards the code
    assign accept  = code_valid & code_ready & en;
    assign ptr_use = dem_en ? ptr : '0;

    dwa_rotator u_dwa_rotator (
        .n        (n_units),
        .ptr      (ptr_use),
        .mask     (mask),
        .ptr_next (ptr_next)
    );

    // Power FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_OFF;
        else     state <= state_next;
    end

    // Power FSM next state and state-decoded outputs
    always_comb begin
        state_next = state;
        pdb        = 1'b0;
        active     = 1'b0;
        code_ready = 1'b0;
        case (state)
            ST_OFF: begin
                if (en) state_next = ST_SETTLE;
            end
            ST_SETTLE: begin
                pdb = 1'b1;
                if (!en)                         state_next = ST_OFF;
                else if (settle_cnt == CNT_LAST) state_next = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                pdb        = 1'b1;
                active     = 1'b1;
                code_ready = 1'b1;
                if (!en) state_next = ST_OFF;
            end
            default: state_next = ST_OFF;
        endcase
    end

    // Settle counter runs only while staying in SETTLE, so each entry starts at 0
    always_ff @(posedge clk) begin
        if (rst)
            settle_cnt <= '0;
        else if (state == ST_SETTLE && state_next == ST_SETTLE)
            settle_cnt <= settle_cnt + 1'b1;
        else
            settle_cnt <= '0;
    end

    // Switch, testbus and pointer registers; entering OFF clears them together with pdb
    always_ff @(posedge clk) begin
        if (rst || state_next == ST_OFF) begin
            atb_ena     <= 2'b00;
            therm_sw    <= '0;
            bin_sw      <= '0;
            bin0_red_sw <= 1'b0;
            sat         <= 1'b0;
            ptr         <= '0;
        end else begin
            atb_ena <= atb_sel;
            if (accept) begin
                therm_sw    <= mask;
                bin_sw      <= {b_bits[NUM_BIN-1:1], b_bits[0] & ~red_sel};
                bin0_red_sw <= b_bits[0] & red_sel;
                sat         <= code_over;
                ptr         <= dem_en ? ptr_next : '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dac_segment_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dac_segment_ctrl
// Description : Self-checking bench for dac_segment_ctrl: directed scenarios
//               with literal expectations, then randomized traffic, all
//               compared every cycle against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dac_segment_ctrl;

    localparam int SETTLE_CYC = 16;
    localparam int CODE_W     = 11;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic              dem_en;
    logic              red_sel;
    logic [1:0]        atb_sel;
    logic              code_valid;
    logic [CODE_W-1:0] code;
    logic              code_ready;
    logic              pdb;
    logic [1:0]        atb_ena;
    logic [16:0]       therm_sw;
    logic [5:0]        bin_sw;
    logic              bin0_red_sw;
    logic              sat;
    logic              active;

    int checks   = 0;
    int failures = 0;
    bit cmp_on   = 1'b0;

    // Model: cycles since power-up (-1 when powered down) and expected registers
    int          m_up    = -1;
    int          m_ptr   = 0;
    logic [16:0] m_therm = '0;
    logic [5:0]  m_bin   = '0;
    logic        m_red   = 1'b0;
    logic        m_sat   = 1'b0;
    logic [1:0]  m_atb   = 2'b00;

    dac_segment_ctrl #(
        .SETTLE_CYC (SETTLE_CYC),
        .CODE_W     (CODE_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .dem_en      (dem_en),
        .red_sel     (red_sel),
        .atb_sel     (atb_sel),
        .code_valid  (code_valid),
        .code        (code),
        .code_ready  (code_ready),
        .pdb         (pdb),
        .atb_ena     (atb_ena),
        .therm_sw    (therm_sw),
        .bin_sw      (bin_sw),
        .bin0_red_sw (bin0_red_sw),
        .sat         (sat),
        .active      (active)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] unit_mask(int n, int p);
        logic [16:0] m;
        m = '0;
        for (int k = 0; k < n; k++) m[(p + k) % 17] = 1'b1;
        return m;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_up    = -1;
        m_ptr   = 0;
        m_therm = '0;
        m_bin   = '0;
        m_red   = 1'b0;
        m_sat   = 1'b0;
        m_atb   = 2'b00;
    endtask

    // Advance the model by one clock edge using the inputs present at that edge
    task automatic model_step();
        int          c;
        int          n;
        logic [5:0]  b;
        if (rst || !en) begin
            model_clear();
        end else begin
            if (m_up >= SETTLE_CYC && code_valid) begin
                c       = (code > CODE_W'(1151)) ? 1151 : int'(code);
                m_sat   = (code > CODE_W'(1151));
                n       = c / 64;
                b       = 6'(c % 64);
                m_therm = unit_mask(n, dem_en ? m_ptr : 0);
                m_ptr   = dem_en ? (m_ptr + n) % 17 : 0;
                m_bin   = red_sel ? {b[5:1], 1'b0} : b;
                m_red   = red_sel & b[0];
            end
            m_up  = (m_up < 0) ? 0 : ((m_up < 1000) ? m_up + 1 : m_up);
            m_atb = atb_sel;
        end
    endtask

    task automatic compare_all();
        chk("pdb",         32'(pdb),         32'(m_up >= 0));
        chk("active",      32'(active),      32'(m_up >= SETTLE_CYC));
        chk("code_ready",  32'(code_ready),  32'(m_up >= SETTLE_CYC));
        chk("atb_ena",     32'(atb_ena),     32'(m_atb));
        chk("therm_sw",    32'(therm_sw),    32'(m_therm));
        chk("bin_sw",      32'(bin_sw),      32'(m_bin));
        chk("bin0_red_sw", 32'(bin0_red_sw), 32'(m_red));
        chk("sat",         32'(sat),         32'(m_sat));
    endtask

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (cmp_on) compare_all();
    end

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic send(int c, bit dem, bit red);
        code       = CODE_W'(c);
        dem_en     = dem;
        red_sel    = red;
        code_valid = 1'b1;
        cycle();
        code_valid = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        en         = 1'b0;
        dem_en     = 1'b0;
        red_sel    = 1'b0;
        atb_sel    = 2'b10;
        code_valid = 1'b0;
        code       = '0;

        // Reset state
        cycle();
        cmp_on = 1'b1;
        cycle();
        chk("rst_pdb",   32'(pdb),        32'h0);
        chk("rst_ready", 32'(code_ready), 32'h0);
        chk("rst_atb",   32'(atb_ena),    32'h0);
        chk("rst_therm", 32'(therm_sw),   32'h0);
        rst = 1'b0;
        cycle();
        chk("off_atb", 32'(atb_ena), 32'h0);

        // Power-up and settle timing
        en = 1'b1;
        cycle();
        chk("pu_pdb",    32'(pdb),     32'h1);
        chk("pu_atb",    32'(atb_ena), 32'h2);
        chk("pu_active", 32'(active),  32'h0);
        repeat (SETTLE_CYC - 1) cycle();
        chk("settle_early", 32'(active), 32'h0);
        cycle();
        chk("settle_active", 32'(active),     32'h1);
        chk("settle_ready",  32'(code_ready), 32'h1);

        // Plain thermometer decode
        send(200, 1'b0, 1'b0);
        chk("c200_therm", 32'(therm_sw),    32'h00007);
        chk("c200_bin",   32'(bin_sw),      32'h08);
        chk("c200_red",   32'(bin0_red_sw), 32'h0);
        chk("c200_sat",   32'(sat),         32'h0);

        // DWA rotation with wrap
        send(5 * 64, 1'b1, 1'b0);
        chk("dwa1_therm", 32'(therm_sw), 32'h0001F);
        send(15 * 64, 1'b1, 1'b0);
        chk("dwa2_therm", 32'(therm_sw), 32'h1FFE7);
        send(64, 1'b1, 1'b0);
        chk("dwa3_ptr3", 32'(therm_sw), 32'h00008);

        // Saturation, hold, redundant LSB
        send(2047, 1'b0, 1'b0);
        chk("sat_flag",  32'(sat),      32'h1);
        chk("sat_therm", 32'(therm_sw), 32'h1FFFF);
        chk("sat_bin",   32'(bin_sw),   32'h3F);
        dem_en  = 1'b1;
        red_sel = 1'b1;
        cycle();
        chk("hold_therm", 32'(therm_sw), 32'h1FFFF);
        send(1, 1'b0, 1'b1);
        chk("red_bin", 32'(bin_sw),      32'h00);
        chk("red_sw",  32'(bin0_red_sw), 32'h1);
        chk("red_sat", 32'(sat),         32'h0);

        // Power-down wins over a simultaneous code
        en         = 1'b0;
        code       = CODE_W'(960);
        code_valid = 1'b1;
        cycle();
        code_valid = 1'b0;
        chk("pd_pdb",   32'(pdb),         32'h0);
        chk("pd_therm", 32'(therm_sw),    32'h0);
        chk("pd_bin",   32'(bin_sw),      32'h0);
        chk("pd_red",   32'(bin0_red_sw), 32'h0);
        chk("pd_atb",   32'(atb_ena),     32'h0);

        // Reset in ACTIVE with P=9, then rotation restarts from 0
        en = 1'b1;
        repeat (SETTLE_CYC + 1) cycle();
        send(9 * 64, 1'b1, 1'b0);
        chk("p9_therm", 32'(therm_sw), 32'h001FF);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("mrst_pdb",    32'(pdb),      32'h0);
        chk("mrst_active", 32'(active),   32'h0);
        chk("mrst_therm",  32'(therm_sw), 32'h0);
        chk("mrst_atb",    32'(atb_ena),  32'h0);
        repeat (SETTLE_CYC + 1) cycle();
        send(3 * 64, 1'b1, 1'b0);
        chk("mrst_p0", 32'(therm_sw), 32'h00007);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            rst        = ($urandom_range(0, 299) == 0);
            en         = ($urandom_range(0, 149) != 0);
            code_valid = 1'($urandom_range(0, 1));
            dem_en     = 1'($urandom_range(0, 3) != 0);
            red_sel    = 1'($urandom_range(0, 1));
            atb_sel    = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       code = CODE_W'($urandom_range(1152, 2047));
                1:       code = CODE_W'(64 * $urandom_range(0, 17));
                default: code = CODE_W'($urandom_range(0, 1151));
            endcase
            cycle();
        end

        @(negedge clk);
        cmp_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
